// File: rtl/rgb565_window_filter.sv
// rgb565_window_filter: builds a 3x3 RGB565 window from two line buffers and applies a
// run-time selectable per-channel filter (pass, Sobel magnitude, 1-2-1 Gaussian).
// Two-stage pipeline: stage 1 holds the window, stage 2 holds the filtered pixel.
module rgb565_window_filter #(
    parameter int unsigned IMG_WIDTH   = 640,
    parameter int unsigned COL_W       = 10,
    parameter int unsigned SOBEL_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [16:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_data
);

    // One colour channel, zero-extended to 6 bits; cmax is 31 for R/B and 63 for G.
    function automatic logic [5:0] chan_filter(input logic [1:0]      md,
                                               input logic [8:0][5:0] p,
                                               input logic [5:0]      cmax);
        logic signed [8:0][9:0] e;
        logic signed [9:0]      gx;
        logic signed [9:0]      gy;
        logic signed [9:0]      ax;
        logic signed [9:0]      ay;
        logic [10:0]            mag;
        logic [9:0]             gsum;
        logic [5:0]             res;
        for (int k = 0; k < 9; k++) begin
            e[k] = signed'({4'b0000, p[k]});
        end
        gx   = (e[2] + e[5] + e[5] + e[8]) - (e[0] + e[3] + e[3] + e[6]);
        gy   = (e[6] + e[7] + e[7] + e[8]) - (e[0] + e[1] + e[1] + e[2]);
        ax   = gx[9] ? -gx : gx;
        ay   = gy[9] ? -gy : gy;
        mag  = ({1'b0, ax} + {1'b0, ay}) >> SOBEL_SHIFT;
        gsum = {4'b0000, p[0]} + ({4'b0000, p[1]} << 1) + {4'b0000, p[2]}
             + ({4'b0000, p[3]} << 1) + ({4'b0000, p[4]} << 2) + ({4'b0000, p[5]} << 1)
             + {4'b0000, p[6]} + ({4'b0000, p[7]} << 1) + {4'b0000, p[8]};
        case (md)
            2'd1:    res = (mag > {5'b00000, cmax}) ? cmax : mag[5:0];
            2'd2:    res = gsum[9:4];
            default: res = p[4];
        endcase
        return res;
    endfunction

    logic                    adv;
    logic                    accept;
    logic                    sof_in;
    logic [15:0]             pix_in;
    logic [COL_W-1:0]        col_q, col_d, pos_col;
    logic [1:0]              row_q, row_d, pos_row;
    logic                    col_last;
    logic [1:0]              mode_q;
    logic [15:0]             lb0_mem [IMG_WIDTH];
    logic [15:0]             lb1_mem [IMG_WIDTH];
    logic [15:0]             lb0_rd;
    logic [15:0]             lb1_rd;
    logic [2:0][2:0][15:0]   w_q;
    logic                    s1_valid_q;
    logic                    s1_border_q;
    logic                    s1_sof_q;
    logic [1:0]              s1_mode_q;
    logic [8:0][5:0]         pr, pg, pb;
    logic [4:0]              r5, b5;
    logic [5:0]              g6;
    logic [15:0]             rgb;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign sof_in   = in_data[16];
    assign pix_in   = in_data[15:0];
    assign lb0_rd   = lb0_mem[pos_col];
    assign lb1_rd   = lb1_mem[pos_col];

    // Position of the incoming pixel (SOF forces the origin) and the counters after it.
    always_comb begin
        pos_col  = sof_in ? '0 : col_q;
        pos_row  = sof_in ? '0 : row_q;
        col_last = (pos_col == COL_W'(IMG_WIDTH - 1));
        col_d    = col_last ? '0 : pos_col + 1'b1;
        row_d    = (col_last && (pos_row != 2'd2)) ? pos_row + 1'b1 : pos_row;
    end

    // Line buffers: read-before-write, lb0 is the previous line, lb1 the one before.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[pos_col] <= lb0_mem[pos_col];
            lb0_mem[pos_col] <= pix_in;
        end
    end

    // Stage 1: counters, mode latch, window shift and per-pixel side information.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= '0;
            w_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_border_q <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_mode_q   <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                if (sof_in) begin
                    mode_q <= mode;
                end
                // A newly latched mode applies to the SOF pixel itself.
                s1_mode_q   <= sof_in ? mode : mode_q;
                s1_sof_q    <= sof_in;
                s1_border_q <= (pos_row < 2'd2) || (pos_col < COL_W'(2));
                for (int i = 0; i < 3; i++) begin
                    w_q[i][0] <= w_q[i][1];
                    w_q[i][1] <= w_q[i][2];
                end
                w_q[0][2] <= lb1_rd;
                w_q[1][2] <= lb0_rd;
                w_q[2][2] <= pix_in;
            end
        end
    end

    // Split the window into channels and filter each one.
    always_comb begin
        pr = '0;
        pg = '0;
        pb = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pr[i*3+j] = {1'b0, w_q[i][j][15:11]};
                pg[i*3+j] = w_q[i][j][10:5];
                pb[i*3+j] = {1'b0, w_q[i][j][4:0]};
            end
        end
        r5  = 5'(chan_filter(s1_mode_q, pr, 6'd31));
        g6  = chan_filter(s1_mode_q, pg, 6'd63);
        b5  = 5'(chan_filter(s1_mode_q, pb, 6'd31));
        rgb = s1_border_q ? 16'h0000 : {r5, g6, b5};
    end

    // Stage 2: registered output, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_data <= {s1_sof_q, rgb};
            end
        end
    end

endmodule

// File: tb/tb_rgb565_window_filter.sv
// Directed bench for rgb565_window_filter with an 8-pixel line.
module tb_rgb565_window_filter;

    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] vec   [0:63];
    logic [1:0]  vmode [0:63];
    int          nvec;

    logic [16:0] cap [0:1023];
    int          ncap = 0;

    always #5 clk = ~clk;

    rgb565_window_filter #(
        .IMG_WIDTH  (W),
        .COL_W      (3),
        .SOBEL_SHIFT(0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    // Record every transferred output pixel in order.
    always @(posedge clk) begin
        if (out_valid && out_ready && ncap < 1024) begin
            cap[ncap] <= out_data;
            ncap      <= ncap + 1;
        end
    end

    // Stream vec[0..nvec-1] with in_valid held high; bp applies out_ready pattern 1,0,0,1.
    task automatic run_vec(input bit bp);
        int          k;
        int          cyc;
        bit          acc;
        bit          was_stall;
        logic [16:0] held;
        k         = 0;
        cyc       = 0;
        was_stall = 1'b0;
        held      = '0;
        while (k < nvec && cyc < 2000) begin
            @(negedge clk);
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            in_valid  = 1'b1;
            in_data   = vec[k];
            mode      = vmode[k];
            #1;
            if (bp && was_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    n_bad++;
                    $display("FAIL hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out_data,
                             held);
                end
            end
            if (bp && k >= 2) begin
                n_cmp++;
                if (in_ready !== out_ready) begin
                    n_bad++;
                    $display("FAIL in_ready_bp cyc=%0d got=%b exp=%b", cyc, in_ready, out_ready);
                end
            end
            acc       = in_ready;
            was_stall = out_valid && !out_ready;
            held      = out_data;
            @(posedge clk);
            if (acc) k++;
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout got=%0d exp=%0d", k, nvec);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        if (out_data !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_out_data got=%h exp=00000", out_data);
        end
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency;
        @(negedge clk);
        mode     = 2'd0;
        in_valid = 1'b1;
        in_data  = {1'b1, 16'h1234};
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early got=%b exp=0", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp += 2;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_valid got=%b exp=1", out_valid);
        end
        if (out_data !== {1'b1, 16'h0000}) begin
            n_bad++;
            $display("FAIL latency_data got=%h exp=10000", out_data);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_drop got=%b exp=0", out_valid);
        end
    endtask

    // Index frame in pass mode; bp selects output backpressure.
    task automatic test_pass(input bit bp);
        int          base;
        int          r;
        int          c;
        logic [16:0] e;
        nvec = 64;
        for (int k = 0; k < 64; k++) begin
            vec[k]   = {(k == 0), 16'(k)};
            vmode[k] = 2'd0;
        end
        base = ncap;
        run_vec(bp);
        n_cmp++;
        if (ncap - base !== 64) begin
            n_bad++;
            $display("FAIL pass_count bp=%0d got=%0d exp=64", bp, ncap - base);
        end
        for (int k = 0; k < 64; k++) begin
            r        = k / 8;
            c        = k % 8;
            e[16]    = (k == 0);
            e[15:0]  = (r < 2 || c < 2) ? 16'h0000 : 16'(k - 9);
            n_cmp++;
            if (cap[base+k] !== e) begin
                n_bad++;
                $display("FAIL pass bp=%0d idx=%0d got=%h exp=%h", bp, k, cap[base+k], e);
            end
        end
    endtask

    task automatic test_sobel;
        int          base;
        int          r;
        int          c;
        logic [16:0] e;
        // Flat white frame: no gradient anywhere.
        nvec = 24;
        for (int k = 0; k < 24; k++) begin
            vec[k]   = {(k == 0), 16'hFFFF};
            vmode[k] = 2'd1;
        end
        base = ncap;
        run_vec(1'b0);
        for (int k = 0; k < 24; k++) begin
            e = {(k == 0), 16'h0000};
            n_cmp++;
            if (cap[base+k] !== e) begin
                n_bad++;
                $display("FAIL sobel_flat idx=%0d got=%h exp=%h", k, cap[base+k], e);
            end
        end
        // Vertical red edge between columns 3 and 4: Gx = 124 saturates to 31.
        nvec = 32;
        for (int k = 0; k < 32; k++) begin
            vec[k]   = {(k == 0), ((k % 8) < 4) ? 16'h0000 : 16'hF800};
            vmode[k] = 2'd1;
        end
        base = ncap;
        run_vec(1'b0);
        for (int k = 0; k < 32; k++) begin
            r       = k / 8;
            c       = k % 8;
            e[16]   = (k == 0);
            e[15:0] = (r >= 2 && (c == 4 || c == 5)) ? 16'hF800 : 16'h0000;
            n_cmp++;
            if (cap[base+k] !== e) begin
                n_bad++;
                $display("FAIL sobel_edge idx=%0d got=%h exp=%h", k, cap[base+k], e);
            end
        end
    endtask

    task automatic test_gauss;
        int          base;
        int          r;
        int          c;
        int          dr;
        int          dc;
        int          wt;
        logic [16:0] e;
        nvec = 24;
        for (int k = 0; k < 24; k++) begin
            vec[k]   = {(k == 0), 16'h8410};
            vmode[k] = 2'd2;
        end
        base = ncap;
        run_vec(1'b0);
        for (int k = 0; k < 24; k++) begin
            r       = k / 8;
            c       = k % 8;
            e[16]   = (k == 0);
            e[15:0] = (r >= 2 && c >= 2) ? 16'h8410 : 16'h0000;
            n_cmp++;
            if (cap[base+k] !== e) begin
                n_bad++;
                $display("FAIL gauss_flat idx=%0d got=%h exp=%h", k, cap[base+k], e);
            end
        end
        // Green impulse at (2,3); output at accept (r,c) is centred on (r-1,c-1).
        nvec = 40;
        for (int k = 0; k < 40; k++) begin
            vec[k]   = {(k == 0), (k == 19) ? 16'h07E0 : 16'h0000};
            vmode[k] = 2'd2;
        end
        base = ncap;
        run_vec(1'b0);
        for (int k = 0; k < 40; k++) begin
            r  = k / 8;
            c  = k % 8;
            dr = r - 3;
            dc = c - 4;
            if (dr < 0) dr = -dr;
            if (dc < 0) dc = -dc;
            wt      = (dr > 1 || dc > 1 || r < 2 || c < 2) ? 0 : (2 - dr) * (2 - dc);
            e[16]   = (k == 0);
            e[15:0] = 16'(((63 * wt) >> 4) << 5);
            n_cmp++;
            if (cap[base+k] !== e) begin
                n_bad++;
                $display("FAIL gauss_impulse idx=%0d got=%h exp=%h", k, cap[base+k], e);
            end
        end
    endtask

    // Mode change without SOF is ignored; SOF at column 5 restarts the counters.
    task automatic test_mode_sof;
        int          base;
        int          r;
        int          c;
        int          j;
        logic [16:0] e;
        nvec = 45;
        for (int k = 0; k < 45; k++) begin
            if (k < 21) begin
                vec[k]   = {(k == 0), 16'(k)};
                vmode[k] = (k >= 10) ? 2'd1 : 2'd0;
            end else begin
                vec[k]   = {(k == 21), 16'(100 + k - 21)};
                vmode[k] = 2'd0;
            end
        end
        base = ncap;
        run_vec(1'b0);
        for (int k = 0; k < 45; k++) begin
            if (k < 21) begin
                r       = k / 8;
                c       = k % 8;
                e[16]   = (k == 0);
                e[15:0] = (r < 2 || c < 2) ? 16'h0000 : 16'(k - 9);
            end else begin
                j       = k - 21;
                r       = j / 8;
                c       = j % 8;
                e[16]   = (j == 0);
                e[15:0] = (r < 2 || c < 2) ? 16'h0000 : 16'(100 + j - 9);
            end
            n_cmp++;
            if (cap[base+k] !== e) begin
                n_bad++;
                $display("FAIL mode_sof idx=%0d got=%h exp=%h", k, cap[base+k], e);
            end
        end
    endtask

    task automatic test_reset_mid;
        int          base;
        int          r;
        int          c;
        logic [16:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mode     = 2'd0;
            in_valid = 1'b1;
            in_data  = {(i == 0), 16'(i)};
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre got=%b exp=1", out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_valid got=%b exp=0", out_valid);
        end
        if (out_data !== 17'h0) begin
            n_bad++;
            $display("FAIL rst_mid_data got=%h exp=00000", out_data);
        end
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // No SOF after reset: the first pixel still lands at (0,0).
        nvec = 24;
        for (int k = 0; k < 24; k++) begin
            vec[k]   = {1'b0, 16'(200 + k)};
            vmode[k] = 2'd0;
        end
        base = ncap;
        run_vec(1'b0);
        for (int k = 0; k < 24; k++) begin
            r       = k / 8;
            c       = k % 8;
            e[16]   = 1'b0;
            e[15:0] = (r < 2 || c < 2) ? 16'h0000 : 16'(200 + k - 9);
            n_cmp++;
            if (cap[base+k] !== e) begin
                n_bad++;
                $display("FAIL rst_mid_frame idx=%0d got=%h exp=%h", k, cap[base+k], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_pass(1'b0);
        test_sobel();
        test_gauss();
        test_pass(1'b1);
        test_mode_sof();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
